// File: rtl/proc_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : proc_muldiv_pkg
// Brief    : Shared encodings for the iterative multiply/divide unit:
//            function codes and the control state enumeration.
// Revision : 1.0 - initial release
// ============================================================================
package proc_muldiv_pkg;

  // Function codes presented on req_fn; 5-7 are reserved and execute as MUL
  localparam logic [2:0] MD_MUL  = 3'd0;
  localparam logic [2:0] MD_DIV  = 3'd1;
  localparam logic [2:0] MD_DIVU = 3'd2;
  localparam logic [2:0] MD_REM  = 3'd3;
  localparam logic [2:0] MD_REMU = 3'd4;

  // Control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed divide/remainder operations need magnitude conversion and sign fix-up
  function automatic logic fn_is_signed(input logic [2:0] fn);
    return (fn == MD_DIV) || (fn == MD_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/proc_dpath_muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : proc_dpath_muldiv_step
// Brief    : One combinational iteration shared by multiply and divide.
//            MUL: shift-add (acc += a when b[0]; a <<= 1; b >>= 1).
//            DIV: restoring step on magnitudes; a shifts dividend bits out
//                 of the top and quotient bits in at the bottom, acc holds
//                 the partial remainder, b holds the divisor.
// Revision : 1.0 - initial release
// ============================================================================
module proc_dpath_muldiv_step #(
  parameter int NBITS = 32
) (
  input  logic [NBITS:0]   acc,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic             is_div,
  output logic [NBITS:0]   next_acc,
  output logic [NBITS-1:0] next_a,
  output logic [NBITS-1:0] next_b
);

  logic [NBITS+1:0] w_rem_sh;
  logic [NBITS+1:0] w_diff;
  logic [NBITS-1:0] w_sum;

  // Partial remainder with the next dividend bit shifted in, and its trial difference
  assign w_rem_sh = {acc, a[NBITS-1]};
  assign w_diff   = w_rem_sh - {2'b00, b};
  assign w_sum    = acc[NBITS-1:0] + (b[0] ? a : '0);

  // Select add-shift or trial-subtract-shift for this iteration
  always_comb begin
    if (is_div) begin
      if (!w_diff[NBITS+1]) begin
        next_acc = w_diff[NBITS:0];
        next_a   = {a[NBITS-2:0], 1'b1};
      end else begin
        next_acc = w_rem_sh[NBITS:0];
        next_a   = {a[NBITS-2:0], 1'b0};
      end
      next_b = b;
    end else begin
      next_acc = {1'b0, w_sum};
      next_a   = {a[NBITS-2:0], 1'b0};
      next_b   = {1'b0, b[NBITS-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/proc_dpath_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : proc_dpath_muldiv_iter
// Brief    : Iterative RV32M multiply/divide unit with val/rdy handshakes.
//            NBITS iterations per operation regardless of function; special
//            divide cases are flagged at accept and substituted at DONE.
// Revision : 1.0 - initial release
// ============================================================================
module proc_dpath_muldiv_iter
  import proc_muldiv_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [2:0]       req_fn,
  input  logic [NBITS-1:0] req_op0,
  input  logic [NBITS-1:0] req_op1,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [NBITS-1:0] resp_msg
);

  localparam int               c_CNT_W    = $clog2(NBITS) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(NBITS);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(1);
  localparam logic [NBITS-1:0] c_INT_MIN  = {1'b1, {(NBITS-1){1'b0}}};

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_fn;
  logic [NBITS:0]     r_acc;
  logic [NBITS-1:0]   r_a;
  logic [NBITS-1:0]   r_b;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div0;
  logic               r_ovf;

  logic               w_accept;
  logic [2:0]         w_fn;
  logic               w_is_div;
  logic               w_signed;
  logic               w_op0_neg;
  logic               w_op1_neg;
  logic [NBITS-1:0]   w_abs0;
  logic [NBITS-1:0]   w_abs1;
  logic [NBITS:0]     w_step_acc;
  logic [NBITS-1:0]   w_step_a;
  logic [NBITS-1:0]   w_step_b;
  logic [NBITS-1:0]   w_quot;
  logic [NBITS-1:0]   w_rem;
  logic [NBITS-1:0]   w_result;

  // Request decode: reserved codes collapse to MUL, signed ops use magnitudes
  assign w_accept  = (r_state == IDLE) && req_val;
  assign w_fn      = (req_fn > MD_REMU) ? MD_MUL : req_fn;
  assign w_is_div  = (w_fn != MD_MUL);
  assign w_signed  = fn_is_signed(w_fn);
  assign w_op0_neg = w_signed && req_op0[NBITS-1];
  assign w_op1_neg = w_signed && req_op1[NBITS-1];
  assign w_abs0    = w_op0_neg ? -req_op0 : req_op0;
  assign w_abs1    = w_op1_neg ? -req_op1 : req_op1;

  proc_dpath_muldiv_step #(
    .NBITS (NBITS)
  ) u_step (
    .acc      (r_acc),
    .a        (r_a),
    .b        (r_b),
    .is_div   (r_fn != MD_MUL),
    .next_acc (w_step_acc),
    .next_a   (w_step_a),
    .next_b   (w_step_b)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: DONE is entered on the iteration that takes the counter to zero
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_val)             w_state_nxt = CALC;
      CALC:    if (r_cnt == c_CNT_LAST) w_state_nxt = DONE;
      DONE:    if (resp_rdy)            w_state_nxt = IDLE;
      default:                          w_state_nxt = IDLE;
    endcase
  end

  // Operand capture at accept, then one iteration per CALC cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_fn    <= MD_MUL;
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= c_CNT_INIT;
      r_fn    <= w_fn;
      r_acc   <= '0;
      r_a     <= w_abs0;
      r_b     <= w_abs1;
      r_neg_q <= w_op0_neg ^ w_op1_neg;
      r_neg_r <= w_op0_neg;
      r_div0  <= w_is_div && (req_op1 == '0);
      r_ovf   <= w_signed && (req_op0 == c_INT_MIN) && (req_op1 == '1);
    end else if (r_state == CALC) begin
      r_cnt   <= r_cnt - 1'b1;
      r_acc   <= w_step_acc;
      r_a     <= w_step_a;
      r_b     <= w_step_b;
    end
  end

  // Sign fix-up and special-case substitution; the fixed-up remainder of a
  // divide-by-zero is already the original dividend
  always_comb begin
    w_quot = r_neg_q ? -r_a : r_a;
    w_rem  = r_neg_r ? -r_acc[NBITS-1:0] : r_acc[NBITS-1:0];
    case (r_fn)
      MD_DIV, MD_DIVU: w_result = r_div0 ? '1 : (r_ovf ? c_INT_MIN : w_quot);
      MD_REM, MD_REMU: w_result = r_ovf ? '0 : w_rem;
      default:         w_result = r_acc[NBITS-1:0];
    endcase
  end

  // Moore outputs decoded from state only
  always_comb begin
    req_rdy  = (r_state == IDLE);
    resp_val = (r_state == DONE);
    resp_msg = (r_state == DONE) ? w_result : '0;
  end

endmodule
`default_nettype wire
